// File: rtl/scan_pattern_engine.sv
// scan_pattern_engine: multi-chain scan load/unload sequencer with overlapped unload compare.
// Optional miscompare diagnostics (fail_vld/vec/pat/bit) are built when SCAN_ENG_DIAG_EN is defined.
module scan_pattern_engine #(
  parameter int NCHAIN    = 4,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  npat,
  input  logic              pat_vld,
  output logic              pat_rdy,
  input  logic [NCHAIN-1:0] pat_si,
  input  logic [NCHAIN-1:0] pat_exp,
  input  logic [NCHAIN-1:0] pat_msk,
  output logic              scan_se,
  output logic              scan_ce,
  output logic [NCHAIN-1:0] scan_si,
  input  logic [NCHAIN-1:0] scan_so,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pattern_number,
  output logic [CNT_W-1:0]  vector_number,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_vld,
  output logic [NCHAIN-1:0] fail_vec,
  output logic [CNT_W-1:0]  fail_pat,
  output logic [CNT_W-1:0]  fail_bit
);

  localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_PRE    = 3'd2;
  localparam logic [2:0] ST_CAPT   = 3'd3;
  localparam logic [2:0] ST_POST   = 3'd4;
  localparam logic [2:0] ST_UNLOAD = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  npat_q, npat_d;
  logic [CNT_W-1:0]  pat_num_q, pat_num_d;
  logic [CNT_W-1:0]  vec_num_q, vec_num_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              done_q, done_d;

  logic              in_stream;
  logic              accept;
  logic              last_beat;
  logic              cmp_en;
  logic [NCHAIN-1:0] mis;
  logic              any_mis;
  logic [CNT_W-1:0]  pat_num_inc;

  assign in_stream   = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign accept      = in_stream && pat_vld;
  assign last_beat   = (bit_cnt_q == LAST_BIT);
  assign pat_num_inc = pat_num_q + CNT_W'(1);

  // While loading pattern 0 the chains still hold unknown data, so nothing is compared.
  assign cmp_en  = accept && !((state_q == ST_SHIFT) && (pat_num_q == '0));
  assign mis     = cmp_en ? ((scan_so ^ pat_exp) & ~pat_msk) : '0;
  assign any_mis = |mis;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    npat_d     = npat_q;
    pat_num_d  = pat_num_q;
    vec_num_d  = vec_num_q;
    fail_cnt_d = fail_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (npat != '0) begin
            state_d    = ST_SHIFT;
            npat_d     = npat;
            bit_cnt_d  = '0;
            pat_num_d  = '0;
            vec_num_d  = '0;
            fail_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT, ST_UNLOAD: begin
        if (accept) begin
          vec_num_d = vec_num_q + CNT_W'(1);
          if (any_mis && (fail_cnt_q != {CNT_W{1'b1}})) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
          if (last_beat) begin
            bit_cnt_d = '0;
            if (state_q == ST_SHIFT) begin
              state_d = ST_PRE;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PRE:  state_d = ST_CAPT;
      ST_CAPT: state_d = ST_POST;
      ST_POST: begin
        // pat_num_q < npat_q always holds here, so the increment cannot wrap.
        if (pat_num_inc < npat_q) begin
          pat_num_d = pat_num_inc;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_UNLOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      npat_q     <= '0;
      pat_num_q  <= '0;
      vec_num_q  <= '0;
      fail_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      npat_q     <= npat_d;
      pat_num_q  <= pat_num_d;
      vec_num_q  <= vec_num_d;
      fail_cnt_q <= fail_cnt_d;
      done_q     <= done_d;
    end
  end

  assign pat_rdy        = in_stream;
  assign scan_se        = in_stream;
  assign scan_ce        = accept || (state_q == ST_CAPT);
  assign scan_si        = (state_q == ST_SHIFT) ? pat_si : '0;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign pattern_number = pat_num_q;
  assign vector_number  = vec_num_q;
  assign fail_cnt       = fail_cnt_q;

`ifdef SCAN_ENG_DIAG_EN
  logic              fail_vld_q;
  logic [NCHAIN-1:0] fail_vec_q;
  logic [CNT_W-1:0]  fail_pat_q;
  logic [CNT_W-1:0]  fail_bit_q;

  // In SHIFT the chains are emptying the previous pattern; in UNLOAD, the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
      fail_pat_q <= '0;
      fail_bit_q <= '0;
    end else begin
      fail_vld_q <= any_mis;
      if (any_mis) begin
        fail_vec_q <= mis;
        fail_pat_q <= (state_q == ST_SHIFT) ? (pat_num_q - CNT_W'(1)) : pat_num_q;
        fail_bit_q <= CNT_W'(bit_cnt_q);
      end
    end
  end

  assign fail_vld = fail_vld_q;
  assign fail_vec = fail_vec_q;
  assign fail_pat = fail_pat_q;
  assign fail_bit = fail_bit_q;
`else
  assign fail_vld = 1'b0;
  assign fail_vec = '0;
  assign fail_pat = '0;
  assign fail_bit = '0;
`endif

endmodule

// File: tb/tb_scan_pattern_engine.sv
// Bench for scan_pattern_engine: 4 chains of 8 bits modelled as shift registers whose capture inverts contents.
// Diagnostic-port checks follow SCAN_ENG_DIAG_EN.
module tb_scan_pattern_engine;
  localparam int NCH = 4;
  localparam int CL  = 8;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, start2, pat_vld;
  logic [CW-1:0]  npat;
  logic [3:0]     npat2;
  logic [NCH-1:0] pat_si, pat_exp, pat_msk, scan_so;
  logic [NCH-1:0] scan_so2 = 4'hF;

  logic           pat_rdy, scan_se, scan_ce, busy, done, fail_vld;
  logic [NCH-1:0] scan_si, fail_vec;
  logic [CW-1:0]  pattern_number, vector_number, fail_cnt, fail_pat, fail_bit;

  logic           pat_rdy2, scan_se2, scan_ce2, busy2, done2, fail_vld2;
  logic [NCH-1:0] scan_si2, fail_vec2;
  logic [3:0]     pattern_number2, vector_number2, fail_cnt2, fail_pat2, fail_bit2;

  scan_pattern_engine #(.NCHAIN(NCH), .CHAIN_LEN(CL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .npat(npat), .pat_vld(pat_vld), .pat_rdy(pat_rdy),
    .pat_si(pat_si), .pat_exp(pat_exp), .pat_msk(pat_msk), .scan_se(scan_se), .scan_ce(scan_ce),
    .scan_si(scan_si), .scan_so(scan_so), .busy(busy), .done(done), .pattern_number(pattern_number),
    .vector_number(vector_number), .fail_cnt(fail_cnt), .fail_vld(fail_vld), .fail_vec(fail_vec),
    .fail_pat(fail_pat), .fail_bit(fail_bit)
  );

  scan_pattern_engine #(.NCHAIN(NCH), .CHAIN_LEN(CL), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .npat(npat2), .pat_vld(pat_vld), .pat_rdy(pat_rdy2),
    .pat_si(pat_si), .pat_exp(pat_exp), .pat_msk(pat_msk), .scan_se(scan_se2), .scan_ce(scan_ce2),
    .scan_si(scan_si2), .scan_so(scan_so2), .busy(busy2), .done(done2), .pattern_number(pattern_number2),
    .vector_number(vector_number2), .fail_cnt(fail_cnt2), .fail_vld(fail_vld2), .fail_vec(fail_vec2),
    .fail_pat(fail_pat2), .fail_bit(fail_bit2)
  );

  // Chain model: shift toward the MSB when se=1, capture (invert) when se=0.
  logic [CL-1:0] chain [NCH];
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) chain[c] <= '0;
      else if (scan_ce) begin
        if (scan_se) chain[c] <= {chain[c][CL-2:0], scan_si[c]};
        else         chain[c] <= ~chain[c];
      end
    end
  end
  for (genvar gi = 0; gi < NCH; gi++) begin : g_so
    assign scan_so[gi] = chain[gi][CL-1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         npat;
    int         duty;
    int         restart;
    int         flip_pat;
    int         flip_beat;
    logic [3:0] flip_mask;
    logic [3:0] msk;
    int         exp_fail;
    int         exp_busy;   // 0 = not checked
    int         exp_beats;
    int         exp_capt;
    logic [3:0] exp_vec;
    int         exp_fpat;
    int         exp_fbit;
  } vec_t;

  function automatic vec_t mk(int np, int du, int rs, int fp, int fb, logic [3:0] fm, logic [3:0] mk_msk,
                              int ef, int eb, int ebeats, int ecapt, logic [3:0] ev, int epat, int ebit);
    vec_t v;
    v.npat = np; v.duty = du; v.restart = rs; v.flip_pat = fp; v.flip_beat = fb;
    v.flip_mask = fm; v.msk = mk_msk; v.exp_fail = ef; v.exp_busy = eb; v.exp_beats = ebeats;
    v.exp_capt = ecapt; v.exp_vec = ev; v.exp_fpat = epat; v.exp_fbit = ebit;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [3:0] L [8][CL];
    int g, ph, b, total, busy_cyc, capt, ce_bad, si_bad, dvld, dpat, dbit;
    logic [3:0] dvec;
    bit seen_done;
    total = (v.npat + 1) * CL;
    g = 0; busy_cyc = 0; capt = 0; ce_bad = 0; si_bad = 0; dvld = 0; dpat = -1; dbit = -1;
    dvec = '0; seen_done = 0;
    for (int p = 0; p < 8; p++)
      for (int k = 0; k < CL; k++) L[p][k] = 4'($urandom);
    @(negedge clk);
    start = 1'b1; npat = CW'(v.npat); pat_vld = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (fail_vld) begin dvld++; dvec = fail_vec; dpat = int'(fail_pat); dbit = int'(fail_bit); end
      if (done) begin seen_done = 1; break; end
      if (busy) busy_cyc++;
      if (v.restart != 0 && cyc == 5) begin start = 1'b1; npat = CW'(7); end
      else start = 1'b0;
      if (g < total) begin
        ph = g / CL; b = g % CL;
        pat_vld = (v.duty != 0) ? (cyc % 2 == 1) : 1'b1;
        pat_si  = (ph < v.npat) ? L[ph][b] : 4'($urandom);
        pat_msk = '0;
        if (ph == 0) pat_exp = 4'($urandom);
        else begin
          pat_exp = ~L[ph-1][b];
          if (ph - 1 == v.flip_pat && b == v.flip_beat) begin
            pat_exp = pat_exp ^ v.flip_mask;
            pat_msk = v.msk;
          end
        end
      end else pat_vld = 1'b0;
      #1;
      if (scan_ce && !scan_se) capt++;
      if (scan_se && (scan_ce != (pat_vld && pat_rdy))) ce_bad++;
      if (pat_vld && pat_rdy) begin
        if (g < v.npat * CL) begin if (scan_si != pat_si) si_bad++; end
        else if (scan_si != '0) si_bad++;
        g++;
      end
      @(negedge clk);
    end
    start = 1'b0; pat_vld = 1'b0;
    $display("vec %0d: npat=%0d duty=%0d beats=%0d busy=%0d capt=%0d fail_cnt=%0d fail_vld=%0d",
             id, v.npat, v.duty, g, busy_cyc, capt, fail_cnt, dvld);
    check("done_seen", seen_done, 1);
    check("beats", g, v.exp_beats);
    check("capt_pulses", capt, v.exp_capt);
    check("ce_only_on_accept", ce_bad, 0);
    check("scan_si", si_bad, 0);
    check("fail_cnt", fail_cnt, v.exp_fail);
    check("vector_number", vector_number, v.exp_beats);
    check("pattern_number", pattern_number, v.npat - 1);
    if (v.exp_busy != 0) check("busy_cycles", busy_cyc, v.exp_busy);
`ifdef SCAN_ENG_DIAG_EN
    check("fail_vld_count", dvld, v.exp_fail);
    if (v.exp_fail > 0) begin
      check("fail_vec", dvec, v.exp_vec);
      check("fail_pat", dpat, v.exp_fpat);
      check("fail_bit", dbit, v.exp_fbit);
    end
`else
    check("fail_vld_tied", dvld, 0);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_run", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [7];

  initial begin
    int rdy_seen, done_cnt, busy_cyc;
    bit seen;
    tbl[0] = mk(2, 0, 0, -1, 0, 4'b0000, 4'b0000, 0, 30, 24, 2, 4'b0000, 0, 0);
    tbl[1] = mk(2, 0, 0,  0, 3, 4'b0100, 4'b0000, 1, 30, 24, 2, 4'b0100, 0, 3);
    tbl[2] = mk(2, 0, 0,  0, 3, 4'b0100, 4'b0100, 0, 30, 24, 2, 4'b0000, 0, 0);
    tbl[3] = mk(2, 1, 0,  0, 3, 4'b0100, 4'b0000, 1,  0, 24, 2, 4'b0100, 0, 3);
    tbl[4] = mk(3, 0, 0,  2, 7, 4'b1001, 4'b0000, 1, 41, 32, 3, 4'b1001, 2, 7);
    tbl[5] = mk(1, 0, 0, -1, 0, 4'b0000, 4'b0000, 0, 19, 16, 1, 4'b0000, 0, 0);
    tbl[6] = mk(2, 0, 1,  1, 0, 4'b0001, 4'b0000, 1, 30, 24, 2, 4'b0001, 1, 0);

    rst = 1'b1; start = 1'b0; start2 = 1'b0; npat = '0; npat2 = '0;
    pat_vld = 1'b1; pat_si = 4'hF; pat_exp = '0; pat_msk = '0;
    repeat (2) @(negedge clk);
    check("rst_pat_rdy", pat_rdy, 0);
    check("rst_scan_se", scan_se, 0);
    check("rst_scan_ce", scan_ce, 0);
    check("rst_scan_si", scan_si, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_counters", {pattern_number, vector_number, fail_cnt}, 0);
    check("rst_diag", {fail_vld, fail_vec, fail_pat, fail_bit}, 0);
    $display("reset: busy=%0d pat_rdy=%0d fail_cnt=%0d", busy, pat_rdy, fail_cnt);
    rst = 1'b0; pat_vld = 1'b0;

    // npat = 0: immediate done, no stream handshake
    @(negedge clk);
    start = 1'b1; npat = '0; pat_vld = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("npat0_done", done, 1);
    check("npat0_busy", busy, 0);
    rdy_seen = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pat_rdy) rdy_seen++;
      if (done) done_cnt++;
    end
    check("npat0_rdy_never", rdy_seen, 0);
    check("npat0_done_pulse", done_cnt, 0);
    $display("npat0: done pulse seen, pat_rdy count=%0d", rdy_seen);
    pat_vld = 1'b0;

    // rst at beat 5 of SHIFT aborts without done
    @(negedge clk);
    start = 1'b1; npat = CW'(2); pat_vld = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_beats_before", vector_number, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pat_vld = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_se", scan_se, 0);
    check("abort_done", done, 0);
    check("abort_vector_number", vector_number, 0);
    $display("abort: busy=%0d scan_se=%0d done=%0d", busy, scan_se, done);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Saturating fail counter on a 4-bit instance: 32 compared beats all fail
    @(negedge clk);
    start2 = 1'b1; npat2 = 4'd4; pat_vld = 1'b1; pat_exp = '0; pat_msk = '0; pat_si = '0;
    @(negedge clk);
    start2 = 1'b0;
    seen = 0; busy_cyc = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (done2) begin seen = 1; break; end
      if (busy2) busy_cyc++;
      @(negedge clk);
    end
    pat_vld = 1'b0;
    $display("saturate: busy=%0d fail_cnt=%0d vector_number=%0d", busy_cyc, fail_cnt2, vector_number2);
    check("sat_done_seen", seen, 1);
    check("sat_busy_cycles", busy_cyc, 52);
    check("sat_fail_cnt", fail_cnt2, 15);
    check("sat_vector_wrap", vector_number2, 8);
    check("sat_pattern_number", pattern_number2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
